// File: rtl/divider_unsigned_pkg.sv
// divider_unsigned_pkg: shared state encoding and constants for the unsigned divider
package divider_unsigned_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // All-ones quotient reported on divide-by-zero and overflow, right-aligned to n bits
    function automatic logic [63:0] err_quotient(input int n);
        return {64{1'b1}} >> (64 - n);
    endfunction
endpackage

// File: rtl/divider_unsigned_step.sv
// divider_unsigned_step: one combinational restoring-division step
module divider_unsigned_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_out,
    output logic         q_bit
);
    logic [N:0] t;
    // Shift in the next dividend bit; a set r_in[N] acts as the carry out of the shift
    always_comb begin
        t     = {r_in[N-1:0], bit_in};
        q_bit = r_in[N] || (t >= {1'b0, divisor});
        r_out = q_bit ? t - {1'b0, divisor} : t;
    end
endmodule

// File: rtl/divider_unsigned.sv
// divider_unsigned: iterative restoring 2N/N unsigned divider, one quotient bit per cycle
module divider_unsigned
    import divider_unsigned_pkg::*;
#(
    parameter int BITWIDTH_INPUT = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*BITWIDTH_INPUT-1:0] dividend,
    input  logic [BITWIDTH_INPUT-1:0]   divisor,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BITWIDTH_INPUT-1:0]   quotient,
    output logic [BITWIDTH_INPUT-1:0]   remainder,
    output logic                        div_by_zero,
    output logic                        overflow
);
    localparam int N  = BITWIDTH_INPUT;
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] ERR_Q = N'(err_quotient(N));

    logic [1:0]    state, state_nxt;
    logic [N:0]    r, r_step;
    logic [N-1:0]  sh, dvs, hi, lo;
    logic [CW-1:0] cnt;
    logic          q_bit, dbz, ovf, accept, err_zero, err_ovf;

    assign hi       = dividend[2*N-1:N];
    assign lo       = dividend[N-1:0];
    assign accept   = in_valid && state == IDLE;
    assign err_zero = divisor == '0;
    assign err_ovf  = hi >= divisor;

    divider_unsigned_step #(.N(N)) u_step (
        .r_in    (r),
        .bit_in  (sh[N-1]),
        .divisor (dvs),
        .r_out   (r_step),
        .q_bit   (q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        state <= !rstn ? IDLE : state_nxt;
    end

    // Next-state logic; error cases skip RUN and go straight to DONE
    always_comb begin
        state_nxt = state == IDLE ? (in_valid ? ((err_zero || err_ovf) ? DONE : RUN) : IDLE) :
                    state == RUN  ? (cnt == '0 ? DONE : RUN) :
                    state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Datapath: sh holds the unconsumed dividend bits and collects quotient bits at the LSB
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r   <= '0;
            sh  <= '0;
            dvs <= '0;
            cnt <= '0;
            dbz <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            dvs <= divisor;
            cnt <= CW'(N - 1);
            dbz <= err_zero;
            ovf <= !err_zero && err_ovf;
            r   <= err_zero ? {1'b0, lo} : err_ovf ? '0 : {1'b0, hi};
            sh  <= (err_zero || err_ovf) ? ERR_Q : lo;
        end else if (state == RUN) begin
            r   <= r_step;
            sh  <= {sh[N-2:0], q_bit};
            cnt <= cnt - 1'b1;
        end
    end

    assign quotient    = sh;
    assign remainder   = r[N-1:0];
    assign div_by_zero = dbz;
    assign overflow    = ovf;
endmodule

// File: tb/tb_divider_unsigned.sv
// tb_divider_unsigned: directed self-checking bench for divider_unsigned
module tb_divider_unsigned;
    localparam int N = 8;

    logic         clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, div_by_zero, overflow;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0, quotient, remainder;
    int total = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    divider_unsigned #(.BITWIDTH_INPUT(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge where out_valid is first seen
    task automatic op(input logic [15:0] dd, input logic [7:0] dv, input int exp_lat,
                      input logic [7:0] eq, input logic [7:0] er, input logic ed, input logic eo);
        int lat;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
        lat = 0;
        while (!out_valid && lat < 3 * N) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(ed));
        check("overflow", 32'(overflow), 32'(eo));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
    endtask

    task automatic retire();
        @(negedge clk);
        check("retire_out_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int stale;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        op(16'd1000, 8'd7, 8, 8'd142, 8'd6, 1'b0, 1'b0);
        retire();
        op(16'h1234, 8'h00, 0, 8'hFF, 8'h34, 1'b1, 1'b0);
        retire();
        op(16'h0500, 8'h05, 0, 8'hFF, 8'h00, 1'b0, 1'b1);
        retire();
        op(16'h04FF, 8'h05, 8, 8'hFF, 8'h04, 1'b0, 1'b0);
        retire();
        op(16'hFEFF, 8'hFF, 8, 8'hFF, 8'hFE, 1'b0, 1'b0);
        retire();
        op(16'h0000, 8'h01, 8, 8'h00, 8'h00, 1'b0, 1'b0);
        retire();

        out_ready = 1'b0;
        op(16'd1000, 8'd7, 8, 8'd142, 8'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd255;
            divisor  = 8'd16;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'd142);
            check("hold_remainder", 32'(remainder), 32'd6);
            check("hold_flags", 32'({div_by_zero, overflow}), 32'd0);
        end
        out_ready = 1'b1;
        retire();
        op(16'd255, 8'd16, 8, 8'd15, 8'd15, 1'b0, 1'b0);
        retire();

        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_flags", 32'({div_by_zero, overflow}), 32'd0);
        rstn = 1'b1;
        stale = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_result", 32'(stale), 32'd0);
        op(16'd100, 8'd9, 8, 8'd11, 8'd1, 1'b0, 1'b0);
        retire();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/divider_unsigned.md
Name: divider_unsigned

Overview:
Iterative restoring unsigned divider, the inverse of the team's unsigned multiplier.
- Divides a 2N-bit dividend (a multiplier-product width) by an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Sits beside the multiplier in arithmetic datapaths (normalisation, scaling, product recovery), with valid/ready handshakes on both sides.

Parameters:
BITWIDTH_INPUT, 8, divisor/quotient/remainder width N; dividend is 2N; must be >= 2

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
dividend  in  2N  unsigned dividend
divisor  in  N  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  N  unsigned quotient
remainder  out  N  unsigned remainder
div_by_zero  out  1  divisor was 0
overflow  out  1  quotient does not fit in N bits (dividend[2N-1:N] >= divisor, divisor != 0)

Behaviour:
- Reset (rstn=0 at an edge): state IDLE, in_ready=1 after the edge.
  - out_valid, quotient, remainder, div_by_zero and overflow are all 0.
  - A reset mid-operation abandons the operation; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. Acceptance happens at an edge with in_valid && in_ready (edge T).
  - divisor==0: go to DONE.
    - quotient = all ones, remainder = dividend[N-1:0], div_by_zero=1, overflow=0.
  - Otherwise, if dividend[2N-1:N] >= divisor: go to DONE.
    - quotient = all ones, remainder = 0, overflow=1, div_by_zero=0.
  - Otherwise: go to RUN.
    - Load partial remainder r (N+1 bits) = {0, dividend[2N-1:N]} and shift register = dividend[N-1:0].
    - Load step counter = N-1.
    - Latch divisor internally; input ports are don't-care after acceptance.
- RUN: in_ready=0, out_valid=0. Each edge performs one restoring step:
  - t = {r[N-1:0], next dividend bit, MSB first}.
  - If t >= divisor: r = t - divisor and quotient bit = 1.
  - Else: r = t and quotient bit = 0.
  - Quotient bits shift in LSB-last.
  - After the step with counter==0 (edge T+N), go to DONE with remainder = r[N-1:0], both flags 0.
  - The invariant r < divisor guarantees the final r fits in N bits.
- DONE: out_valid=1, in_ready=0. quotient, remainder and flags stay stable until out_valid && out_ready at an edge, then go to IDLE.
  - in_ready rises the cycle after the output handshake; there is no same-cycle accept/retire.
- Latency:
  - Normal operation: out_valid is first high after edge T+N (N cycles after acceptance).
  - Error cases: out_valid is high after edge T (1 cycle).
- Throughput: one operation per N+2 cycles minimum under continuous valid/ready.
- Outputs are registered. Values outside DONE are don't-care except after reset, where they are 0.
- Widths: all comparisons and subtractions are N+1-bit unsigned; no truncation before the final remainder.

Decomposition:
- Package divider_unsigned_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the error-quotient constant function (all ones of width N).
- Sub-module divider_unsigned_step: a combinational single restoring step.
  - Parameter N.
  - Inputs: r_in[N:0], bit_in, divisor[N-1:0].
  - Outputs: r_out[N:0], q_bit.
  - Instantiated once in the top level; unit-testable alone.

Test Plan:
- N=8, dividend=16'd1000, divisor=8'd7, out_ready=1 -> quotient=142, remainder=6, flags 0; out_valid exactly 8 cycles after the accept edge, high 1 cycle.
- dividend=16'h1234, divisor=0 -> quotient=8'hFF, remainder=8'h34, div_by_zero=1, overflow=0; out_valid 1 cycle after accept.
- dividend=16'h0500, divisor=8'h05 -> quotient=8'hFF, remainder=0, overflow=1; dividend=16'h04FF, divisor=8'h05 -> quotient=8'hFF, remainder=4, no flag (boundary).
- dividend=16'hFEFF, divisor=8'hFF -> quotient=8'hFF, remainder=8'hFE; dividend=0, divisor=1 -> quotient=0, remainder=0.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs and flags stable, in_ready=0, in_valid ignored; release -> in_ready=1 next cycle, back-to-back op 16'd255/8'd16 -> quotient=15, remainder=15.
- Assert rstn=0 for one edge 3 cycles into RUN -> out_valid=0 and all outputs 0 after the edge, in_ready=1; then 16'd100/8'd9 -> quotient=11, remainder=1, no stale result emitted.
